// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial line among N byte requesters.
// Frame on txd: start 0, D7..D0 MSB first, end 0, then GAP idle-high cycles.
module serial_tx_arbiter #(
    parameter int N   = 4,
    parameter int GAP = 1,
    parameter int GW  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [8*N-1:0]    data,
    output logic [N-1:0]      ack,
    output logic              txd,
    output logic              busy,
    output logic [GW-1:0]     grant_id,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_END   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [7:0]      shreg_r, shreg_s;
    logic [2:0]      bit_cnt_r, bit_cnt_s;
    logic [3:0]      gap_cnt_r, gap_cnt_s;
    logic [GW-1:0]   ptr_r, ptr_s;
    logic            txd_r, txd_s;
    logic [N-1:0]    ack_r, ack_s;
    logic            busy_r, busy_s;
    logic [GW-1:0]   grant_r, grant_s;
    logic            frame_done_r, frame_done_s;

    logic            win_found_s;
    logic [GW-1:0]   win_id_s;
    logic [7:0]      win_byte_s;
    logic [GW-1:0]   win_next_ptr_s;
    logic            win_take_s;

    // Index ptr+offs wrapped modulo N (N need not be a power of two).
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return GW'(s);
    endfunction

    // Round-robin winner search starting at ptr, plus the winner's byte.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        win_byte_s  = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (!win_found_s && req[wrap_idx(ptr_r, k)]) begin
                win_found_s = 1'b1;
                win_id_s    = wrap_idx(ptr_r, k);
            end else begin
                win_found_s = win_found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == win_id_s) begin
                win_byte_s = data[8*i +: 8];
            end else begin
                win_byte_s = win_byte_s;
            end
        end
        if (win_id_s == GW'(N-1)) begin
            win_next_ptr_s = '0;
        end else begin
            win_next_ptr_s = win_id_s + GW'(1);
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        bit_cnt_s    = bit_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        ptr_s        = ptr_r;
        txd_s        = txd_r;
        ack_s        = '0;
        busy_s       = busy_r;
        grant_s      = grant_r;
        frame_done_s = 1'b0;
        win_take_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                txd_s  = 1'b1;
                busy_s = 1'b0;
                if (win_found_s) begin
                    win_take_s = 1'b1;
                end else begin
                    win_take_s = 1'b0;
                end
            end
            ST_START: begin
                state_s   = ST_DATA;
                txd_s     = shreg_r[7];
                shreg_s   = {shreg_r[6:0], 1'b0};
                bit_cnt_s = 3'd0;
            end
            ST_DATA: begin
                if (bit_cnt_r == 3'd7) begin
                    state_s      = ST_END;
                    txd_s        = 1'b0;
                    frame_done_s = 1'b1;
                end else begin
                    txd_s     = shreg_r[7];
                    shreg_s   = {shreg_r[6:0], 1'b0};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                end
            end
            ST_END: begin
                state_s   = ST_GAP;
                txd_s     = 1'b1;
                gap_cnt_s = 4'd0;
            end
            ST_GAP: begin
                txd_s = 1'b1;
                if (gap_cnt_r == 4'(GAP-1)) begin
                    if (win_found_s) begin
                        win_take_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                txd_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase

        // A win overrides whatever IDLE/GAP decided: launch the start bit now.
        if (win_take_s) begin
            state_s = ST_START;
            txd_s   = 1'b0;
            ack_s   = N'(1) << win_id_s;
            shreg_s = win_byte_s;
            grant_s = win_id_s;
            ptr_s   = win_next_ptr_s;
            busy_s  = 1'b1;
        end else begin
            ack_s = ack_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            gap_cnt_r    <= 4'd0;
            ptr_r        <= '0;
            txd_r        <= 1'b1;
            ack_r        <= '0;
            busy_r       <= 1'b0;
            grant_r      <= '0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            bit_cnt_r    <= bit_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            ptr_r        <= ptr_s;
            txd_r        <= txd_s;
            ack_r        <= ack_s;
            busy_r       <= busy_s;
            grant_r      <= grant_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign txd        = txd_r;
    assign ack        = ack_r;
    assign busy       = busy_r;
    assign grant_id   = grant_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: two instances (GAP=1 and GAP=3)
// plus a behavioural frame receiver on the GAP=1 line.
module tb_serial_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req1 = 4'b0000;
    logic [3:0]  req3 = 4'b0000;
    logic [31:0] data = 32'h0;

    logic [3:0]  ack1, ack3;
    logic        txd1, txd3, busy1, busy3, fd1, fd3;
    logic [1:0]  gid1, gid3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fd_cnt  = 0;
    int log1_id[$], log1_cyc[$], log3_id[$], log3_cyc[$];
    int rx_q[$];
    int rx_pos = -1;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_sh = 8'h00;

    serial_tx_arbiter #(.N(4), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .data(data), .ack(ack1), .txd(txd1),
        .busy(busy1), .grant_id(gid1), .frame_done(fd1)
    );

    serial_tx_arbiter #(.N(4), .GAP(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .data(data), .ack(ack3), .txd(txd3),
        .busy(busy3), .grant_id(gid3), .frame_done(fd3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return 99;
    endfunction

    // Grant logs, one-hot ack check and frame_done counter.
    always @(negedge clk) begin
        if (!rst && ack1 != 4'b0000) begin
            check("ack1_onehot", 32'($onehot(ack1)), 32'd1);
            for (int i = 0; i < 4; i++)
                if (ack1[i]) begin log1_id.push_back(i); log1_cyc.push_back(cyc); end
        end
        if (!rst && ack3 != 4'b0000) begin
            for (int i = 0; i < 4; i++)
                if (ack3[i]) begin log3_id.push_back(i); log3_cyc.push_back(cyc); end
        end
        if (!rst && fd1) fd_cnt++;
    end

    // Receiver model: start on a 1->0 transition, 8 data bits MSB first, end bit 0.
    always @(negedge clk) begin
        if (rst) begin
            rx_pos = -1;
        end else if (rx_pos < 0) begin
            if (rx_prev && !txd1) rx_pos = 0;
        end else if (rx_pos < 8) begin
            rx_sh = {rx_sh[6:0], txd1};
            rx_pos++;
        end else begin
            if (!txd1) rx_q.push_back(int'(rx_sh));
            rx_pos = -1;
        end
        rx_prev = txd1;
    end

    task automatic do_reset();
        rst  = 1'b1;
        req1 = 4'b0000;
        req3 = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        log1_id.delete(); log1_cyc.delete(); log3_id.delete(); log3_cyc.delete();
        rx_q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        logic [10:0] exp_bits;
        int fd_base;

        // Reset state and single A5 frame from requester 2
        do_reset();
        check("rst_txd", txd1, 1);
        check("rst_ack", ack1, 0);
        check("rst_busy", busy1, 0);
        check("rst_fd", fd1, 0);
        check("rst_gid", gid1, 0);
        check("rst_txd_g3", txd3, 1);
        data = 32'h00A5_0000;
        req1 = 4'b0100;
        exp_bits = 11'b01010010101;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            if (j == 0) begin
                check("single_ack", ack1, 4'b0100);
                check("single_gid", gid1, 2);
                req1 = 4'b0000;
            end
            if (j == 1) check("single_ack_pulse", ack1, 0);
            check($sformatf("single_txd%0d", j), txd1, exp_bits[10-j]);
            check($sformatf("single_fd%0d", j), fd1, (j == 9) ? 1 : 0);
            check($sformatf("single_busy%0d", j), busy1, 1);
        end
        @(negedge clk);
        check("single_idle_busy", busy1, 0);
        check("single_idle_txd", txd1, 1);

        // All four requesting continuously on both GAP settings
        do_reset();
        req1 = 4'b1111;
        req3 = 4'b1111;
        repeat (70) @(negedge clk);
        req1 = 4'b0000;
        req3 = 4'b0000;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_g1_id%0d", k), qget(log1_id, k), k % 4);
            check($sformatf("rr_g3_id%0d", k), qget(log3_id, k), k % 4);
        end
        for (int k = 1; k < 5; k++) begin
            check($sformatf("rr_g1_period%0d", k), qget(log1_cyc, k) - qget(log1_cyc, k-1), 11);
            check($sformatf("rr_g3_period%0d", k), qget(log3_cyc, k) - qget(log3_cyc, k-1), 13);
        end

        // Pointer fairness: req[1] held, req[3] raised during the first frame
        do_reset();
        req1 = 4'b0010;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 3) req1[3] = 1'b1;
            if (ack1[3]) req1[3] = 1'b0;
        end
        req1 = 4'b0000;
        repeat (15) @(negedge clk);
        check("fair_id0", qget(log1_id, 0), 1);
        check("fair_id1", qget(log1_id, 1), 3);
        check("fair_id2", qget(log1_id, 2), 1);
        check("fair_id3", qget(log1_id, 3), 1);

        // Withdrawal: req[0] pulsed for one DATA cycle only
        do_reset();
        data = 32'h0012_0000;
        req1 = 4'b0100;
        @(negedge clk);
        check("wd_ack2", ack1, 4'b0100);
        req1 = 4'b0000;
        repeat (3) @(negedge clk);
        req1[0] = 1'b1;
        @(negedge clk);
        req1[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("wd_nacks", log1_id.size(), 1);
        check("wd_rx_byte", qget(rx_q, 0), 32'h12);

        // Reset during the 4th data bit, then ptr must be back at 0
        do_reset();
        data = 32'h00FF_0000;
        req1 = 4'b0100;
        @(negedge clk);
        check("mid_ack2", ack1, 4'b0100);
        req1 = 4'b0000;
        fd_base = fd_cnt;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_txd", txd1, 1);
        check("mid_busy", busy1, 0);
        check("mid_ack", ack1, 0);
        check("mid_fd", fd1, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_no_fd", fd_cnt - fd_base, 0);
        req1 = 4'b1010;
        @(negedge clk);
        check("mid_regrant_gid", gid1, 1);
        check("mid_regrant_ack", ack1, 4'b0010);
        req1 = 4'b0000;
        repeat (15) @(negedge clk);

        // Loopback: 00, FF, 3C, C3 back-to-back from requesters 0..3
        do_reset();
        data = 32'hC33C_FF00;
        req1 = 4'b1111;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req1 = req1 & ~ack1;
        end
        req1 = 4'b0000;
        repeat (10) @(negedge clk);
        check("loop_count", rx_q.size(), 4);
        check("loop_w0", qget(rx_q, 0), 32'h00);
        check("loop_w1", qget(rx_q, 1), 32'hFF);
        check("loop_w2", qget(rx_q, 2), 32'h3C);
        check("loop_w3", qget(rx_q, 3), 32'hC3);
        check("loop_fd_count", fd_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
